conv_frame_sequencer: RTL and testbench

//  Frame-level controller for the stage-1 convolution core (cnn_top core path).
//  - On a start pulse, fetches one IX*IY 8-bit image from a synchronous image ROM in raster order.
//  - Streams the pixels to the core's i_valid/i_pixel input.
//  - Counts the core's o_core_valid results until one full OUT_W*OUT_H feature map is seen,

---
 rtl/conv_frame_sequencer.sv | 148 ++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the stage-1 convolution core: streams one image from a
// synchronous ROM into the core and counts the feature-map outputs that come back.
module conv_frame_sequencer #(
    parameter int I_F_BW        = 8,
    parameter int IX            = 28,
    parameter int IY            = 28,
    parameter int KX            = 5,
    parameter int KY            = 5,
    parameter int OUT_W         = IX - KX + 1,
    parameter int OUT_H         = IY - KY + 1,
    parameter int DRAIN_TIMEOUT = 256,
    parameter int ADDR_BW       = $clog2(IX * IY)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_start,
    input  logic               i_hold,
    output logic               o_rom_en,
    output logic [ADDR_BW-1:0] o_rom_addr,
    input  logic [I_F_BW-1:0]  i_rom_data,
    output logic               o_pix_valid,
    output logic [I_F_BW-1:0]  o_pixel,
    input  logic               i_core_valid,
    output logic [9:0]         o_out_cnt,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err_timeout,
    output logic               o_err_overrun,
    output logic [2:0]         o_state
);

    // Pixel and result streams carry a valid qualifier only: there is no ready,
    // so every cycle with valid high transfers exactly one item.

    localparam int IDLE_BW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [ADDR_BW-1:0] LAST_ADDR = ADDR_BW'(IX * IY - 1);
    localparam logic [9:0]         OUT_N     = 10'(OUT_W * OUT_H);
    localparam logic [IDLE_BW-1:0] IDLE_LAST = IDLE_BW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_DRAIN  = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t               state, next_state;
    logic [ADDR_BW-1:0]   addr;
    logic [9:0]           out_cnt, cnt_next;
    logic [IDLE_BW-1:0]   idle_cnt;
    logic                 err_to, err_ov;
    logic                 rom_en, en_d1;
    logic                 start_acc, busy, count_inc, overrun_hit;
    logic                 pix_valid;
    logic [I_F_BW-1:0]    pixel;

    always_comb begin
        next_state  = state;
        rom_en      = 1'b0;
        start_acc   = 1'b0;
        count_inc   = 1'b0;
        overrun_hit = 1'b0;
        busy        = (state == S_STREAM) || (state == S_DRAIN);

        if (i_core_valid) begin
            if (busy && (out_cnt != OUT_N)) count_inc   = 1'b1;
            else                            overrun_hit = 1'b1;
        end
        cnt_next = out_cnt + {9'd0, count_inc};

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    start_acc  = 1'b1;
                    next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!i_hold) begin
                    rom_en = 1'b1;
                    if (addr == LAST_ADDR) next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A result arriving on the timeout cycle is counted and cancels the timeout.
                if (cnt_next == OUT_N)                        next_state = S_DONE;
                else if (!i_core_valid && idle_cnt == IDLE_LAST) next_state = S_ERR;
            end
            S_DONE:  next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            addr     <= '0;
            out_cnt  <= '0;
            idle_cnt <= '0;
            err_to   <= 1'b0;
            err_ov   <= 1'b0;
        end else begin
            state <= next_state;

            if (start_acc)   addr <= '0;
            else if (rom_en) addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;

            out_cnt <= start_acc ? '0 : cnt_next;

            // The idle counter reaching DRAIN_TIMEOUT is the same edge that enters ERR.
            if (state == S_DRAIN && !i_core_valid) idle_cnt <= idle_cnt + 1'b1;
            else                                   idle_cnt <= '0;

            if (start_acc)                                     err_to <= 1'b0;
            else if (state == S_DRAIN && next_state == S_ERR)  err_to <= 1'b1;

            if (start_acc)        err_ov <= 1'b0;
            else if (overrun_hit) err_ov <= 1'b1;
        end
    end

    // Two-stage pixel path: ROM data lands one cycle after the read, then is registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_d1     <= 1'b0;
            pix_valid <= 1'b0;
            pixel     <= '0;
        end else begin
            en_d1     <= rom_en;
            pix_valid <= en_d1;
            if (en_d1) pixel <= i_rom_data;
        end
    end

    assign o_rom_en      = rom_en;
    assign o_rom_addr    = addr;
    assign o_pix_valid   = pix_valid;
    assign o_pixel       = pixel;
    assign o_out_cnt     = out_cnt;
    assign o_busy        = busy;
    assign o_done        = (state == S_DONE);
    assign o_err_timeout = err_to;
    assign o_err_overrun = err_ov;
    assign o_state       = state;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Bench for conv_frame_sequencer: random ROM images, random core result timing,
// pixel scoreboard and frame-level expectations derived from the frame rules.
module tb_conv_frame_sequencer;

    localparam int PIX_N         = 28 * 28;
    localparam int OUT_N         = 24 * 24;
    localparam int DRAIN_TIMEOUT = 256;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       i_start = 1'b0;
    logic       i_hold = 1'b0;
    logic       i_core_valid = 1'b0;
    logic [7:0] i_rom_data = '0;
    logic       o_rom_en, o_pix_valid, o_busy, o_done, o_err_timeout, o_err_overrun;
    logic [9:0] o_rom_addr, o_out_cnt;
    logic [7:0] o_pixel;
    logic [2:0] o_state;

    conv_frame_sequencer dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_hold(i_hold),
        .o_rom_en(o_rom_en), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
        .o_pix_valid(o_pix_valid), .o_pixel(o_pixel), .i_core_valid(i_core_valid),
        .o_out_cnt(o_out_cnt), .o_busy(o_busy), .o_done(o_done),
        .o_err_timeout(o_err_timeout), .o_err_overrun(o_err_overrun), .o_state(o_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous image ROM
    logic [7:0] mem [PIX_N];
    always @(posedge clk) if (o_rom_en) i_rom_data <= mem[int'(o_rom_addr)];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // scoreboard / monitor
    logic [7:0] exp_q[$];
    int  pix_seen, first_cyc, last_cyc, done_cnt, done_cyc, to_cyc, ov_cyc;
    bit  en_h1, en_h2;

    always @(negedge clk) begin
        if (!reset_n) begin
            en_h1 = 1'b0;
            en_h2 = 1'b0;
        end else begin
            check("pix_latency", o_pix_valid, en_h2);
            en_h2 = en_h1;
            en_h1 = o_rom_en;
            if (o_pix_valid) begin
                if (exp_q.size() == 0) check("pix_extra", pix_seen + 1, PIX_N);
                else                   check("pixel", o_pixel, exp_q.pop_front());
                if (pix_seen == 0) first_cyc = cyc;
                last_cyc = cyc;
                pix_seen++;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (o_err_timeout && to_cyc < 0) to_cyc = cyc;
            if (o_err_overrun && ov_cyc < 0) ov_cyc = cyc;
        end
    end

    task automatic load_image();
        exp_q.delete();
        for (int i = 0; i < PIX_N; i++) begin
            mem[i] = 8'($urandom);
            exp_q.push_back(mem[i]);
        end
        pix_seen = 0; done_cnt = 0; done_cyc = -1; to_cyc = -1; ov_cyc = -1;
        first_cyc = -1; last_cyc = -1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    // One frame: n_valid core results (from pixel 400 on, 0..1 idle cycles apart),
    // an optional single hold burst at hold_addr, an optional extra start at pixel dup_at.
    task automatic run_frame(input int n_valid, input int hold_addr, input int hold_len,
                             input int dup_at);
        int  sent, gap, hold_left, tail, c;
        bit  hold_used, dup_used;
        int  vcyc[$];
        load_image();
        pulse_start();
        check("busy_after_start", o_busy, 1);
        check("cnt_cleared", o_out_cnt, 0);
        check("errs_cleared", {o_err_timeout, o_err_overrun}, 0);
        sent = 0; gap = 0; hold_left = 0; tail = -1; hold_used = 0; dup_used = 0;
        for (c = 0; c < 5000 && tail != 0; c++) begin
            @(posedge clk); #1;
            if (hold_left > 0) begin
                i_hold = 1'b1;
                hold_left--;
            end else if (!hold_used && hold_len > 0 && o_busy && int'(o_rom_addr) == hold_addr) begin
                i_hold = 1'b1;
                hold_left = hold_len - 1;
                hold_used = 1;
            end else begin
                i_hold = 1'b0;
            end
            i_start = (!dup_used && dup_at >= 0 && pix_seen >= dup_at);
            if (i_start) dup_used = 1;
            if (sent < n_valid && pix_seen >= 400 && gap == 0) begin
                i_core_valid = 1'b1;
                sent++;
                vcyc.push_back(cyc);
                gap = $urandom_range(0, 1);
            end else begin
                i_core_valid = 1'b0;
                if (gap > 0) gap--;
            end
            if (tail < 0 && sent == n_valid && (done_cnt > 0 || to_cyc >= 0)) tail = 4;
            else if (tail > 0) tail--;
        end
        i_core_valid = 1'b0; i_hold = 1'b0; i_start = 1'b0;
        check("frame_bound", tail, 0);
        @(negedge clk);
        check("pix_total", pix_seen, PIX_N);
        check("pix_span", last_cyc - first_cyc + 1, PIX_N + hold_len);
        check("done_count", done_cnt, (n_valid >= OUT_N) ? 1 : 0);
        check("out_cnt", o_out_cnt, (n_valid < OUT_N) ? n_valid : OUT_N);
        check("busy_end", o_busy, 0);
        check("err_timeout", o_err_timeout, (n_valid < OUT_N) ? 1 : 0);
        check("err_overrun", o_err_overrun, (n_valid > OUT_N) ? 1 : 0);
        if (vcyc.size() >= OUT_N)
            check("done_time", done_cyc, vcyc[OUT_N-1] + 1);
        else if (vcyc.size() > 0)
            check("timeout_time", to_cyc, vcyc[vcyc.size()-1] + 1 + DRAIN_TIMEOUT);
        if (vcyc.size() > OUT_N)
            check("overrun_time", ov_cyc, vcyc[OUT_N] + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_valid"}, o_pix_valid, 0);
        check({tag, "_rom_en"}, o_rom_en, 0);
        check({tag, "_rom_addr"}, o_rom_addr, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_out_cnt"}, o_out_cnt, 0);
        check({tag, "_errs"}, {o_err_timeout, o_err_overrun}, 0);
        check({tag, "_pixel"}, o_pixel, 0);
    endtask

    task automatic reset_mid_frame();
        load_image();
        pulse_start();
        check("ovr_cleared_by_start", o_err_overrun, 0);
        for (int c = 0; c < 2000 && pix_seen < 400; c++) @(posedge clk);
        check("reach_pix400", pix_seen, 400);
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        run_frame(OUT_N, -1, 0, -1);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        run_frame(OUT_N,     -1,  0, -1);   // nominal
        run_frame(OUT_N,     100, 10, -1);  // hold burst at address 100
        run_frame(OUT_N - 1, -1,  0, -1);   // one result short: drain timeout
        run_frame(OUT_N + 1, -1,  0, -1);   // one result extra: overrun
        run_frame(OUT_N,     -1,  0, 300);  // start while busy
        repeat (3)
            run_frame(OUT_N, $urandom_range(1, PIX_N - 1), $urandom_range(1, 20),
                      ($urandom_range(0, 1) == 1) ? $urandom_range(1, 700) : -1);
        reset_mid_frame();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
